// File: rtl/burst_rr_scheduler_pkg.sv
// Shared types for the burst round-robin scheduler: default sizing,
// burst length type and scheduler state encoding.
package burst_rr_scheduler_pkg;

  localparam int DEF_NUM_REQUESTERS = 4;
  localparam int DEF_MAX_BURST      = 8;
  localparam int DEF_LEN_WIDTH      = $clog2(DEF_MAX_BURST);

  typedef logic [DEF_LEN_WIDTH-1:0] burst_len_t;

  typedef enum logic {
    SCHED_IDLE,
    SCHED_BURST
  } sched_state_t;

endpackage

// File: rtl/burst_rr_scheduler_rr_pick.sv
// Combinational rotating-priority picker: returns the first set bit of mask
// at or after ptr, wrapping modulo NUM_REQUESTERS, as a one-hot vector.
module rr_pick
  import burst_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQUESTERS = DEF_NUM_REQUESTERS,
  parameter int IDX_WIDTH      = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] mask,
  input  logic [IDX_WIDTH-1:0]      ptr,
  output logic [NUM_REQUESTERS-1:0] winner
);

  int   idx;
  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      idx = (int'(ptr) + i) % NUM_REQUESTERS;
      if (!found && mask[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/burst_rr_scheduler.sv
// Round-robin owner of a multi-beat resource port; the winner keeps the port
// for its whole burst and the next winner is chosen on the final beat.
module burst_rr_scheduler
  import burst_rr_scheduler_pkg::*;
#(
  parameter  int NUM_REQUESTERS = DEF_NUM_REQUESTERS,
  parameter  int MAX_BURST      = DEF_MAX_BURST,
  parameter  int LEN_WIDTH      = $clog2(MAX_BURST),
  localparam int IDX_WIDTH      = $clog2(NUM_REQUESTERS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQUESTERS-1:0]           request,
  input  logic [NUM_REQUESTERS*LEN_WIDTH-1:0] request_len,
  input  logic                                beat_ready,
  output logic [NUM_REQUESTERS-1:0]           grant_oh,
  output logic [IDX_WIDTH-1:0]                grant_idx,
  output logic                                grant_valid,
  output logic [NUM_REQUESTERS-1:0]           beat_done,
  output logic                                burst_last
);

  sched_state_t               state;
  logic [LEN_WIDTH-1:0]       count;
  logic [IDX_WIDTH-1:0]       ptr;
  logic [IDX_WIDTH-1:0]       next_ptr;
  logic [NUM_REQUESTERS-1:0]  pick_mask;
  logic [IDX_WIDTH-1:0]       pick_ptr;
  logic [NUM_REQUESTERS-1:0]  winner;
  logic [IDX_WIDTH-1:0]       win_idx;
  logic [LEN_WIDTH-1:0]       win_len;
  logic                       accepted;

  assign grant_valid = |grant_oh;
  assign accepted    = beat_ready & grant_valid;
  assign beat_done   = {NUM_REQUESTERS{accepted}} & grant_oh;
  assign burst_last  = accepted & (count == '0);

  assign next_ptr = (grant_idx == IDX_WIDTH'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;

  // While bursting the picker only matters on burst_last: it looks ahead from
  // the slot after the owner with the owner itself excluded.
  assign pick_mask = (state == SCHED_BURST) ? (request & ~grant_oh) : request;
  assign pick_ptr  = (state == SCHED_BURST) ? next_ptr : ptr;

  rr_pick #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .IDX_WIDTH     (IDX_WIDTH)
  ) u_pick (
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .winner(winner)
  );

  always_comb begin
    win_idx = '0;
    win_len = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (winner[i]) begin
        win_idx = IDX_WIDTH'(i);
        win_len = request_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCHED_IDLE;
      grant_oh  <= '0;
      grant_idx <= '0;
      count     <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        SCHED_IDLE: begin
          if (|winner) begin
            state     <= SCHED_BURST;
            grant_oh  <= winner;
            grant_idx <= win_idx;
            count     <= win_len;
          end
        end
        SCHED_BURST: begin
          if (burst_last) begin
            ptr <= next_ptr;
            if (|winner) begin
              grant_oh  <= winner;
              grant_idx <= win_idx;
              count     <= win_len;
            end else begin
              state     <= SCHED_IDLE;
              grant_oh  <= '0;
              grant_idx <= '0;
            end
          end else if (accepted) begin
            count <= count - 1'b1;
          end
        end
        default: state <= SCHED_IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_oh));
  a_done_subset:  assert property (@(posedge clk) disable iff (reset) (beat_done & ~grant_oh) == '0);
  a_valid_match:  assert property (@(posedge clk) disable iff (reset) grant_valid == (|grant_oh));

endmodule

// File: tb/tb_burst_rr_scheduler.sv
// Directed scenarios for burst_rr_scheduler; completed bursts are checked
// against a scoreboard of expected (owner, beat count) pairs.
module tb_burst_rr_scheduler;

  localparam int N  = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  request = '0;
  logic [N*LW-1:0] request_len = '0;
  logic          beat_ready = 1'b0;
  logic [N-1:0]  grant_oh;
  logic [1:0]    grant_idx;
  logic          grant_valid;
  logic [N-1:0]  beat_done;
  logic          burst_last;

  typedef struct {
    int idx;
    int beats;
  } burst_t;

  burst_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int beat_cnt = 0;
  bit rdy_pat [0:4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  burst_rr_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .request    (request),
    .request_len(request_len),
    .beat_ready (beat_ready),
    .grant_oh   (grant_oh),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .beat_done  (beat_done),
    .burst_last (burst_last)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_len(input int unit, input int len);
    request_len[unit*LW +: LW] = LW'(len);
  endtask

  task automatic push(input int idx, input int beats);
    burst_t b;
    b.idx   = idx;
    b.beats = beats;
    sb_q.push_back(b);
  endtask

  // Scoreboard monitor: every completed burst must match the next expectation.
  always @(negedge clk) begin
    burst_t e;
    if (reset) begin
      beat_cnt = 0;
    end else begin
      if (beat_done != '0) beat_cnt = beat_cnt + 1;
      if (burst_last) begin
        if (sb_q.size() == 0) begin
          check_val("sb_unexpected_burst", int'(grant_idx), -1);
        end else begin
          e = sb_q.pop_front();
          check_val("sb_owner", int'(grant_idx), e.idx);
          check_val("sb_beats", beat_cnt, e.beats);
          $display("burst done: owner %0d beats %0d", grant_idx, beat_cnt);
        end
        beat_cnt = 0;
      end
    end
  end

  initial begin
    // Reset state
    tick();
    sample();
    check_val("rst_grant_oh", int'(grant_oh), 0);
    check_val("rst_grant_idx", int'(grant_idx), 0);
    check_val("rst_grant_valid", int'(grant_valid), 0);
    check_val("rst_beat_done", int'(beat_done), 0);
    check_val("rst_burst_last", int'(burst_last), 0);
    tick();
    reset = 1'b0;

    // Fairness: all request, len 0 -> 0,1,2,3,0 back to back
    tick();
    request = 4'b1111;
    for (int u = 0; u < N; u++) set_len(u, 0);
    beat_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(k % N, 1);
    sample();
    check_val("t2_idle_c0", int'(grant_valid), 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) request = '0;
      sample();
      check_val("t2_valid", int'(grant_valid), 1);
      check_val("t2_order", int'(grant_idx), (c - 1) % N);
      check_val("t2_done", int'(beat_done), 1 << ((c - 1) % N));
      check_val("t2_last", int'(burst_last), 1);
    end
    tick();
    sample();
    check_val("t2_idle_after", int'(grant_valid), 0);

    // Single burst: unit 0, len 3
    tick();
    request = 4'b0001;
    set_len(0, 3);
    push(0, 4);
    sample();
    check_val("t1_idle_c0", int'(grant_valid), 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      sample();
      check_val("t1_grant_oh", int'(grant_oh), 1);
      check_val("t1_beat_done", int'(beat_done), 1);
      check_val("t1_last", int'(burst_last), (c == 4) ? 1 : 0);
    end
    tick();
    request = '0;
    sample();
    check_val("t1_idle_c5", int'(grant_valid), 0);

    // Stall: unit 3, len 2, beat_ready 1,0,0,1,1
    tick();
    request = 4'b1000;
    set_len(3, 2);
    beat_ready = 1'b0;
    push(3, 3);
    sample();
    for (int c = 1; c <= 5; c++) begin
      tick();
      beat_ready = rdy_pat[c-1];
      sample();
      check_val("t3_grant_held", int'(grant_oh), 8);
      check_val("t3_beat_done", int'(beat_done), rdy_pat[c-1] ? 8 : 0);
      check_val("t3_last", int'(burst_last), (c == 5) ? 1 : 0);
    end
    tick();
    request = '0;
    beat_ready = 1'b1;
    sample();
    check_val("t3_idle_after", int'(grant_valid), 0);

    // Mid-burst arrival: unit 2 len 3, unit 1 arrives on beat 2
    tick();
    request = 4'b0100;
    set_len(2, 3);
    push(2, 4);
    sample();
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) begin
        request = 4'b0110;
        set_len(1, 1);
        push(1, 2);
      end
      sample();
      check_val("t4_owner2_held", int'(grant_idx), 2);
      check_val("t4_last", int'(burst_last), (c == 4) ? 1 : 0);
    end
    tick();
    request = 4'b0010;
    sample();
    check_val("t4_no_bubble", int'(grant_valid), 1);
    check_val("t4_next_owner", int'(grant_idx), 1);
    tick();
    sample();
    check_val("t4_owner1_last", int'(burst_last), 1);
    tick();
    request = '0;
    sample();
    check_val("t4_idle_after", int'(grant_valid), 0);

    // Reset during burst, then pointer restarts at 0
    tick();
    request = 4'b0010;
    set_len(1, 3);
    sample();
    tick();
    sample();
    check_val("t5_owner1", int'(grant_idx), 1);
    tick();
    reset = 1'b1;
    sample();
    check_val("t5_rst_grant", int'(grant_oh), 0);
    check_val("t5_rst_done", int'(beat_done), 0);
    check_val("t5_rst_last", int'(burst_last), 0);
    tick();
    reset = 1'b0;
    request = 4'b0101;
    set_len(0, 0);
    set_len(2, 0);
    push(0, 1);
    push(2, 1);
    sample();
    check_val("t5_idle_release", int'(grant_valid), 0);
    tick();
    sample();
    check_val("t5_ptr_from_0", int'(grant_idx), 0);
    tick();
    request = 4'b0100;
    sample();
    check_val("t5_then_unit2", int'(grant_idx), 2);
    tick();
    request = '0;
    sample();
    check_val("t5_idle_after", int'(grant_valid), 0);

    // Owner-only re-request: one idle cycle before the re-grant
    tick();
    request = 4'b0001;
    set_len(0, 0);
    push(0, 1);
    push(0, 1);
    sample();
    tick();
    sample();
    check_val("t6_first_grant", int'(grant_oh), 1);
    tick();
    sample();
    check_val("t6_idle_gap", int'(grant_valid), 0);
    tick();
    request = '0;
    sample();
    check_val("t6_regrant", int'(grant_oh), 1);
    tick();
    sample();
    check_val("t6_idle_after", int'(grant_valid), 0);

    tick();
    tick();
    check_val("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
